mmio_test_host: RTL and testbench
=================================

// Module: mmio_test_host
// PURPOSE
//   Synthesizable compliance-test host for the RV32I core: word memory serving instruction and
//   data ports, plus MMIO signature FIFO, halt detector and watchdog. Parametrised successor of
//   the ad-hoc testbench memory: byte strobes, configurable read latency, buffered signature
//   stream with backpressure, explicit run/drain/done/timeout state machine.
// PARAMETERS
//   MEMSIZE_WORDS  131072        memory depth in 32-bit words (power of 2)
//   RD_LATENCY     1             imem/dmem read latency in cycles, 0..3 (0 = combinational)
//   SIG_DEPTH      16            signature FIFO depth (power of 2, >=2)
//   SIG_ADDR       32'hF0000004  signature MMIO word address
//   HALT_ADDR      32'hF0000000  halt MMIO word address
//   HALT_MAGIC     32'hCAFECAFE  value written to HALT_ADDR that ends the test
//   TIMEOUT        1000000       watchdog limit in cycles from reset release
// PORTS
//   sysclk         in   1   clock; all logic rising-edge
//   rst_in         in   1   synchronous reset, active-high
//   imem_addr      in   32  instruction fetch byte address
//   imem_data      out  32  fetched word, RD_LATENCY cycles after imem_addr
//   dmem_rd_en     in   1   data read request
//   dmem_rd_addr   in   32  data read byte address
//   dmem_rd_data   out  32  read word, valid with dmem_rd_valid
//   dmem_rd_valid  out  1   read data valid (dmem_rd_en delayed RD_LATENCY cycles)
//   dmem_wr_en     in   1   data write request
//   dmem_wr_addr   in   32  data write byte address
//   dmem_wr_data   in   32  write data
//   dmem_wr_strb   in   4   byte enables, bit i -> data[8i+7:8i]
//   sig_valid      out  1   signature word available
//   sig_data       out  32  head of signature FIFO
//   sig_ready      in   1   consumer pops head when sig_valid & sig_ready
//   sig_overflow   out  1   sticky: a signature write was dropped (FIFO full)
//   halted         out  1   test completed and signature FIFO drained
//   timeout        out  1   watchdog expired before halt
//   cycle_count    out  32  cycles since reset release, frozen in DONE/TIMEOUT
// BEHAVIOUR
//   Reset: all outputs 0, FIFO empty, state RUN, read pipes cleared. Memory array not reset.
//   Indexing: word index = addr[$clog2(MEMSIZE_WORDS)+1:2]; higher bits ignored (aliasing).
//   Reads: RD_LATENCY register stages on both ports; dmem_rd_valid tracks dmem_rd_en through
//     same pipe. Same-cycle write+read of one word returns OLD data.
//   Writes (RUN only): each strobed byte updated at posedge. Write to SIG_ADDR updates memory
//     AND pushes dmem_wr_data (full word, strobes ignored) into FIFO; FIFO full -> push dropped,
//     sig_overflow set until reset. Push and pop same cycle when full: pop then push, no drop.
//   Write to HALT_ADDR with data==HALT_MAGIC and strb==4'hF: memory not written, RUN->DRAIN.
//     Any other HALT_ADDR write is a normal memory write.
//   States: RUN -> DRAIN on halt; RUN -> TIMEOUT when cycle_count == TIMEOUT-1 (halt same
//     cycle wins). DRAIN: all dmem writes ignored; reads/fetch still served; -> DONE when FIFO
//     empty (same cycle as last pop). DONE: halted=1. TIMEOUT: timeout=1, FIFO keeps draining.
//     DONE/TIMEOUT exit only via rst_in.
//   cycle_count: increments each cycle in RUN/DRAIN, saturates at 2^32-1.
//   Reset mid-operation: FIFO contents, overflow, state, counters discarded next edge.
// TESTING
//   1 RD_LATENCY=1: write 32'h12345678 strb F @0x100, read 0x100 -> rd_data 12345678, valid 1 cycle after rd_en.
//   2 Strobes: word=0, write 32'hAABBCCDD strb 4'b0101 -> read returns 32'h00BB00DD.
//   3 SIG_DEPTH=4, sig_ready=0: 5 writes to F0000004 -> sig_valid=1, overflow=1, pops yield first 4 values.
//   4 Write CAFECAFE @F0000000 with 2 sigs queued -> DRAIN, halted=1 the cycle after the 2nd pop; later writes ignored.
//   5 Write 32'h00000001 @F0000000 -> memory updated, state stays RUN, halted=0.
//   6 TIMEOUT=50, no halt -> timeout=1 after 50 cycles, cycle_count frozen at 50; rst_in clears all.

Source files
------------

// File: rtl/mmio_test_host.sv
// Compliance-test host for an RV32I core: shared word memory behind the fetch and data ports,
// an MMIO signature FIFO with backpressure, a halt detector and a cycle watchdog.
module mmio_test_host #(
    parameter int unsigned MEMSIZE_WORDS = 131072,
    parameter int unsigned RD_LATENCY    = 1,
    parameter int unsigned SIG_DEPTH     = 16,
    parameter logic [31:0] SIG_ADDR      = 32'hF0000004,
    parameter logic [31:0] HALT_ADDR     = 32'hF0000000,
    parameter logic [31:0] HALT_MAGIC    = 32'hCAFECAFE,
    parameter int unsigned TIMEOUT       = 1000000
) (
    input  logic        sysclk,
    input  logic        rst_in,
    input  logic [31:0] imem_addr,
    output logic [31:0] imem_data,
    input  logic        dmem_rd_en,
    input  logic [31:0] dmem_rd_addr,
    output logic [31:0] dmem_rd_data,
    output logic        dmem_rd_valid,
    input  logic        dmem_wr_en,
    input  logic [31:0] dmem_wr_addr,
    input  logic [31:0] dmem_wr_data,
    input  logic [3:0]  dmem_wr_strb,
    output logic        sig_valid,
    output logic [31:0] sig_data,
    input  logic        sig_ready,
    output logic        sig_overflow,
    output logic        halted,
    output logic        timeout,
    output logic [31:0] cycle_count
);
    localparam int unsigned AW = $clog2(MEMSIZE_WORDS);
    localparam int unsigned PW = $clog2(SIG_DEPTH);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DONE,
        ST_TIMEOUT
    } state_t;

    state_t state;
    state_t state_next;

    logic [31:0]   mem [MEMSIZE_WORDS];
    logic [AW-1:0] imem_idx;
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] wr_idx;
    logic [31:0]   imem_raw;
    logic [31:0]   rd_raw;

    logic run;
    logic halt_cmd;
    logic wr_mem;

    logic [31:0]   fifo [SIG_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          fifo_full;
    logic          sig_pop;
    logic          sig_push_req;
    logic          sig_push;

    logic [31:0] cycle_cnt;
    logic        unused_addr_bits;

    // Upper address bits alias onto the same word; only the index bits matter.
    assign imem_idx = imem_addr[AW+1:2];
    assign rd_idx   = dmem_rd_addr[AW+1:2];
    assign wr_idx   = dmem_wr_addr[AW+1:2];
    assign unused_addr_bits = ^{imem_addr[31:AW+2], imem_addr[1:0],
                                dmem_rd_addr[31:AW+2], dmem_rd_addr[1:0]};

    assign run      = (state == ST_RUN);
    assign halt_cmd = run && dmem_wr_en && (dmem_wr_addr == HALT_ADDR) &&
                      (dmem_wr_data == HALT_MAGIC) && (dmem_wr_strb == 4'hF);
    assign wr_mem   = !rst_in && run && dmem_wr_en && !halt_cmd;

    always_ff @(posedge sysclk) begin
        if (wr_mem) begin
            for (int i = 0; i < 4; i++) begin
                if (dmem_wr_strb[i]) begin
                    mem[wr_idx][8*i +: 8] <= dmem_wr_data[8*i +: 8];
                end
            end
        end
    end

    assign imem_raw = mem[imem_idx];
    assign rd_raw   = mem[rd_idx];

    // Read stages sample the array before this edge's write lands, so a colliding
    // write+read returns the old word at every latency.
    generate
        if (RD_LATENCY == 0) begin : g_comb
            assign imem_data     = imem_raw;
            assign dmem_rd_data  = rd_raw;
            assign dmem_rd_valid = dmem_rd_en;
        end else begin : g_pipe
            logic [31:0]           im_pipe [RD_LATENCY];
            logic [31:0]           rd_pipe [RD_LATENCY];
            logic [RD_LATENCY-1:0] vld_pipe;

            always_ff @(posedge sysclk) begin
                if (rst_in) begin
                    for (int i = 0; i < RD_LATENCY; i++) begin
                        im_pipe[i] <= '0;
                        rd_pipe[i] <= '0;
                    end
                    vld_pipe <= '0;
                end else begin
                    im_pipe[0]  <= imem_raw;
                    rd_pipe[0]  <= rd_raw;
                    vld_pipe[0] <= dmem_rd_en;
                    for (int i = 1; i < RD_LATENCY; i++) begin
                        im_pipe[i]  <= im_pipe[i-1];
                        rd_pipe[i]  <= rd_pipe[i-1];
                        vld_pipe[i] <= vld_pipe[i-1];
                    end
                end
            end

            assign imem_data     = im_pipe[RD_LATENCY-1];
            assign dmem_rd_data  = rd_pipe[RD_LATENCY-1];
            assign dmem_rd_valid = vld_pipe[RD_LATENCY-1];
        end
    endgenerate

    // Signature FIFO: a pop frees the slot that a same-cycle push into a full FIFO reuses.
    assign sig_valid    = (count != '0);
    assign fifo_full    = (count == (PW+1)'(SIG_DEPTH));
    assign sig_pop      = sig_valid && sig_ready;
    assign sig_push_req = run && dmem_wr_en && (dmem_wr_addr == SIG_ADDR);
    assign sig_push     = sig_push_req && (!fifo_full || sig_pop);
    assign sig_data     = sig_valid ? fifo[rd_ptr] : '0;

    always_ff @(posedge sysclk) begin
        if (sig_push) begin
            fifo[wr_ptr] <= dmem_wr_data;
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst_in) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            sig_overflow <= 1'b0;
        end else begin
            if (sig_push) wr_ptr <= wr_ptr + 1'b1;
            if (sig_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(sig_push) - (PW+1)'(sig_pop);
            if (sig_push_req && !sig_push) sig_overflow <= 1'b1;
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst_in) begin
            state     <= ST_RUN;
            cycle_cnt <= '0;
        end else begin
            state <= state_next;
            if ((state == ST_RUN || state == ST_DRAIN) && cycle_cnt != '1) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RUN: begin
                if (halt_cmd) begin
                    state_next = ST_DRAIN;
                end else if (cycle_cnt == 32'(TIMEOUT - 1)) begin
                    state_next = ST_TIMEOUT;
                end
            end
            ST_DRAIN: begin
                if (count == '0 || (count == (PW+1)'(1) && sig_pop)) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = state;
        endcase
    end

    assign halted      = (state == ST_DONE);
    assign timeout     = (state == ST_TIMEOUT);
    assign cycle_count = cycle_cnt;
endmodule

// File: tb/tb_mmio_test_host.sv
// Bench for mmio_test_host: directed literal cases, a watchdog instance, and randomized traffic
// checked every cycle against a queue/array model of the host.
module tb_mmio_test_host;
    localparam int MEMW    = 1024;
    localparam int SIGD    = 4;
    localparam int TO_MAIN = 300;
    localparam int TO_WD   = 50;
    localparam logic [31:0] SIG_A  = 32'hF0000004;
    localparam logic [31:0] HALT_A = 32'hF0000000;
    localparam logic [31:0] MAGIC  = 32'hCAFECAFE;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst          = 1'b1;
    logic [31:0] imem_addr    = '0;
    logic        dmem_rd_en   = 1'b0;
    logic [31:0] dmem_rd_addr = '0;
    logic        dmem_wr_en   = 1'b0;
    logic [31:0] dmem_wr_addr = '0;
    logic [31:0] dmem_wr_data = '0;
    logic [3:0]  dmem_wr_strb = '0;
    logic        sig_ready    = 1'b0;
    logic [31:0] imem_data, dmem_rd_data, sig_data, cycle_count;
    logic        dmem_rd_valid, sig_valid, sig_overflow, halted, timeout;

    mmio_test_host #(.MEMSIZE_WORDS(MEMW), .RD_LATENCY(1), .SIG_DEPTH(SIGD),
                     .TIMEOUT(TO_MAIN)) dut (
        .sysclk(clk), .rst_in(rst), .imem_addr(imem_addr), .imem_data(imem_data),
        .dmem_rd_en(dmem_rd_en), .dmem_rd_addr(dmem_rd_addr), .dmem_rd_data(dmem_rd_data),
        .dmem_rd_valid(dmem_rd_valid), .dmem_wr_en(dmem_wr_en), .dmem_wr_addr(dmem_wr_addr),
        .dmem_wr_data(dmem_wr_data), .dmem_wr_strb(dmem_wr_strb), .sig_valid(sig_valid),
        .sig_data(sig_data), .sig_ready(sig_ready), .sig_overflow(sig_overflow),
        .halted(halted), .timeout(timeout), .cycle_count(cycle_count)
    );

    logic        w_rst       = 1'b1;
    logic [31:0] w_imem_addr = '0;
    logic        w_rd_en     = 1'b0;
    logic [31:0] w_rd_addr   = '0;
    logic        w_wr_en     = 1'b0;
    logic [31:0] w_wr_addr   = '0;
    logic [31:0] w_wr_data   = '0;
    logic [3:0]  w_wr_strb   = '0;
    logic [31:0] w_imem_data, w_rd_data, w_sig_data, w_cycle_count;
    logic        w_rd_valid, w_sig_valid, w_sig_overflow, w_halted, w_timeout;

    mmio_test_host #(.MEMSIZE_WORDS(64), .RD_LATENCY(0), .SIG_DEPTH(2),
                     .TIMEOUT(TO_WD)) wd (
        .sysclk(clk), .rst_in(w_rst), .imem_addr(w_imem_addr), .imem_data(w_imem_data),
        .dmem_rd_en(w_rd_en), .dmem_rd_addr(w_rd_addr), .dmem_rd_data(w_rd_data),
        .dmem_rd_valid(w_rd_valid), .dmem_wr_en(w_wr_en), .dmem_wr_addr(w_wr_addr),
        .dmem_wr_data(w_wr_data), .dmem_wr_strb(w_wr_strb), .sig_valid(w_sig_valid),
        .sig_data(w_sig_data), .sig_ready(1'b0), .sig_overflow(w_sig_overflow),
        .halted(w_halted), .timeout(w_timeout), .cycle_count(w_cycle_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: sparse word memory, signature queue, phase and counter.
    typedef enum int {M_RUN, M_DRAIN, M_DONE, M_TIMEOUT} mstate_t;
    logic [31:0] m_mem [int];
    logic [31:0] exp_q [$];
    mstate_t     m_st = M_RUN;
    logic [31:0] m_cnt = '0;
    logic        m_ovf = 1'b0;
    logic        m_rd_valid = 1'b0;
    logic [31:0] m_rd_data = '0;
    logic [31:0] m_im_data = '0;
    bit          m_rd_known = 1'b0;
    bit          m_im_known = 1'b0;
    bit          model_ok = 1'b0;

    function automatic int widx(input logic [31:0] a);
        return int'((a / 32'd4) % 32'(MEMW));
    endfunction

    task automatic model_step();
        int ri, ii, wi;
        bit pop, halt_cmd;
        logic [31:0] old_cnt, tmp;
        ri = widx(dmem_rd_addr);
        ii = widx(imem_addr);
        wi = widx(dmem_wr_addr);
        if (rst) begin
            m_rd_valid = 1'b0; m_rd_data = '0; m_rd_known = 1'b1;
            m_im_data = '0; m_im_known = 1'b1;
            exp_q.delete();
            m_st = M_RUN; m_cnt = '0; m_ovf = 1'b0; model_ok = 1'b1;
        end else begin
            m_rd_valid = dmem_rd_en;
            m_rd_known = m_mem.exists(ri) != 0;
            if (m_rd_known) m_rd_data = m_mem[ri];
            m_im_known = m_mem.exists(ii) != 0;
            if (m_im_known) m_im_data = m_mem[ii];
            if (model_ok) begin
                pop = (exp_q.size() > 0) && sig_ready;
                halt_cmd = (m_st == M_RUN) && dmem_wr_en && dmem_wr_addr == HALT_A &&
                           dmem_wr_data == MAGIC && dmem_wr_strb == 4'hF;
                if (pop) void'(exp_q.pop_front());
                if (m_st == M_RUN && dmem_wr_en && !halt_cmd) begin
                    if (dmem_wr_strb == 4'hF) begin
                        m_mem[wi] = dmem_wr_data;
                    end else if (m_mem.exists(wi) != 0) begin
                        tmp = m_mem[wi];
                        for (int b = 0; b < 4; b++)
                            if (dmem_wr_strb[b]) tmp[8*b +: 8] = dmem_wr_data[8*b +: 8];
                        m_mem[wi] = tmp;
                    end
                    if (dmem_wr_addr == SIG_A) begin
                        if (exp_q.size() < SIGD) exp_q.push_back(dmem_wr_data);
                        else m_ovf = 1'b1;
                    end
                end
                old_cnt = m_cnt;
                if ((m_st == M_RUN || m_st == M_DRAIN) && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
                if (m_st == M_RUN) begin
                    if (halt_cmd) m_st = M_DRAIN;
                    else if (old_cnt == 32'(TO_MAIN - 1)) m_st = M_TIMEOUT;
                end else if (m_st == M_DRAIN) begin
                    if (exp_q.size() == 0) m_st = M_DONE;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        model_step();
        #2;
        if (model_ok) begin
            chk("sig_valid", 32'(sig_valid), 32'(exp_q.size() > 0));
            chk("sig_data", sig_data, (exp_q.size() > 0) ? exp_q[0] : 32'h0);
            chk("sig_overflow", 32'(sig_overflow), 32'(m_ovf));
            chk("halted", 32'(halted), 32'(m_st == M_DONE));
            chk("timeout", 32'(timeout), 32'(m_st == M_TIMEOUT));
            chk("cycle_count", cycle_count, m_cnt);
            chk("rd_valid", 32'(dmem_rd_valid), 32'(m_rd_valid));
            if (m_rd_valid && m_rd_known) chk("rd_data", dmem_rd_data, m_rd_data);
            if (m_im_known) chk("imem_data", imem_data, m_im_data);
        end
    end

    task automatic idle_inputs();
        dmem_rd_en = 1'b0; dmem_wr_en = 1'b0; dmem_wr_strb = '0; sig_ready = 1'b0;
        imem_addr = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        dmem_wr_en = 1'b1; dmem_wr_addr = a; dmem_wr_data = d; dmem_wr_strb = s;
        @(posedge clk);
        #1 dmem_wr_en = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
        @(negedge clk);
        dmem_rd_en = 1'b1; dmem_rd_addr = a;
        chk({nm, "_pre_valid"}, 32'(dmem_rd_valid), 32'd0);
        @(posedge clk);
        #1 dmem_rd_en = 1'b0;
        #2;
        chk({nm, "_valid"}, 32'(dmem_rd_valid), 32'd1);
        chk({nm, "_data"}, dmem_rd_data, exp);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) a = a + 32'(MEMW * 4);
        return a;
    endfunction

    task automatic rand_cycle(input int halt_pct);
        int k;
        @(negedge clk);
        rst = ($urandom_range(0, 399) == 0);
        imem_addr = rand_addr();
        dmem_rd_en = ($urandom_range(0, 1) == 1);
        dmem_rd_addr = rand_addr();
        dmem_wr_en = ($urandom_range(0, 2) != 0);
        dmem_wr_data = $urandom();
        dmem_wr_strb = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
        k = $urandom_range(0, 99);
        if (k < 20) begin
            dmem_wr_addr = SIG_A;
        end else if (k < 20 + halt_pct) begin
            dmem_wr_addr = HALT_A; dmem_wr_data = MAGIC; dmem_wr_strb = 4'hF;
        end else if (k < 25 + halt_pct) begin
            dmem_wr_addr = HALT_A;
        end else begin
            dmem_wr_addr = rand_addr();
        end
        sig_ready = ($urandom_range(0, 2) == 0);
    endtask

    logic [31:0] vals [5] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003,
                              32'h4444_0004, 32'h5555_0005};

    initial begin
        do_reset();
        chk("reset_cycle_count", cycle_count, 32'd0);
        chk("reset_halted", 32'(halted), 32'd0);
        chk("reset_timeout", 32'(timeout), 32'd0);
        chk("reset_sig_valid", 32'(sig_valid), 32'd0);
        chk("reset_rd_valid", 32'(dmem_rd_valid), 32'd0);

        wr(32'h100, 32'h12345678, 4'hF);
        rd(32'h100, 32'h12345678, "t1");

        wr(32'h104, 32'h0, 4'hF);
        wr(32'h104, 32'hAABBCCDD, 4'b0101);
        rd(32'h104, 32'h00BB00DD, "t2");

        // A non-magic halt write is ordinary memory and keeps the test running.
        wr(HALT_A, 32'h1, 4'hF);
        rd(HALT_A, 32'h1, "t5");
        repeat (3) @(posedge clk);
        #3 chk("t5_halted", 32'(halted), 32'd0);

        sig_ready = 1'b0;
        for (int i = 0; i < 5; i++) wr(SIG_A, vals[i], (i == 2) ? 4'h1 : 4'hF);
        #2;
        chk("t3_valid", 32'(sig_valid), 32'd1);
        chk("t3_overflow", 32'(sig_overflow), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sig_ready = 1'b1;
            chk("t3_pop", sig_data, vals[i]);
        end
        @(negedge clk);
        sig_ready = 1'b0;
        chk("t3_empty", 32'(sig_valid), 32'd0);

        do_reset();
        chk("t4_overflow_cleared", 32'(sig_overflow), 32'd0);
        wr(32'h200, 32'h11111111, 4'hF);
        wr(SIG_A, 32'hA1A1A1A1, 4'hF);
        wr(SIG_A, 32'hA2A2A2A2, 4'hF);
        wr(HALT_A, MAGIC, 4'hF);
        #2 chk("t4_drain_not_halted", 32'(halted), 32'd0);
        wr(32'h200, 32'h22222222, 4'hF);
        wr(SIG_A, 32'h33333333, 4'hF);
        @(negedge clk);
        sig_ready = 1'b1;
        chk("t4_pop1", sig_data, 32'hA1A1A1A1);
        @(posedge clk);
        #1 sig_ready = 1'b0;
        #2 chk("t4_halted_mid", 32'(halted), 32'd0);
        @(negedge clk);
        sig_ready = 1'b1;
        chk("t4_pop2", sig_data, 32'hA2A2A2A2);
        @(posedge clk);
        #1 sig_ready = 1'b0;
        #2 chk("t4_halted", 32'(halted), 32'd1);
        rd(32'h200, 32'h11111111, "t4_ignored_wr");

        // Watchdog instance: combinational reads and timeout freeze.
        @(negedge clk);
        w_rst = 1'b0;
        w_wr_en = 1'b1; w_wr_addr = 32'h40; w_wr_data = 32'h1; w_wr_strb = 4'hF;
        @(negedge clk);
        w_wr_data = 32'h2; w_rd_en = 1'b1; w_rd_addr = 32'h40;
        #1;
        chk("wd_rd_valid", 32'(w_rd_valid), 32'd1);
        chk("wd_rd_old", w_rd_data, 32'h1);
        @(negedge clk);
        w_wr_en = 1'b0; w_rd_en = 1'b0; w_imem_addr = 32'h40;
        #1 chk("wd_imem_new", w_imem_data, 32'h2);
        for (int e = 3; e <= 60; e++) begin
            @(posedge clk);
            #3;
            chk("wd_cycle_count", w_cycle_count, 32'((e < TO_WD) ? e : TO_WD));
            chk("wd_timeout", 32'(w_timeout), 32'(e >= TO_WD));
        end
        chk("wd_not_halted", 32'(w_halted), 32'd0);
        @(negedge clk);
        w_rst = 1'b1;
        @(posedge clk);
        #3;
        chk("wd_rst_timeout", 32'(w_timeout), 32'd0);
        chk("wd_rst_count", w_cycle_count, 32'd0);
        chk("wd_rst_overflow", 32'(w_sig_overflow), 32'd0);
        chk("wd_rst_sig_valid", 32'(w_sig_valid), 32'd0);

        for (int s = 0; s < 6; s++) begin
            do_reset();
            for (int w = 0; w < 16; w++) wr(32'(w * 4), $urandom(), 4'hF);
            for (int c = 0; c < 500; c++) rand_cycle((s % 2 == 0) ? 1 : 0);
        end
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        repeat (4) @(posedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
